// File: rtl/sync_pkg.sv
// Constants shared between data_synchronizer and its receive buffer so that
// both ends of the crossing agree on word width and buffer sizing.
package sync_pkg;

  localparam int SYNC_BUS_WIDTH = 8;
  localparam int SYNC_DEPTH     = 4;

endpackage : sync_pkg

// File: rtl/sync_buf_mem.sv
// DEPTH x BUS_WIDTH register array: one synchronous write port and one
// combinational read port. Contents are not reset.
module sync_buf_mem
  import sync_pkg::*;
#(
  parameter  int BUS_WIDTH = SYNC_BUS_WIDTH,
  parameter  int DEPTH     = SYNC_DEPTH,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_W-1:0]    waddr,
  input  logic [BUS_WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]    raddr,
  output logic [BUS_WIDTH-1:0] rdata
);

  logic [BUS_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule : sync_buf_mem

// File: rtl/sync_word_buffer.sv
// Show-ahead receive FIFO behind data_synchronizer: captures a word on each
// enable_pulse, hands it out over valid/ready and flags words dropped when full.
module sync_word_buffer
  import sync_pkg::*;
#(
  parameter  int BUS_WIDTH = SYNC_BUS_WIDTH,
  parameter  int DEPTH     = SYNC_DEPTH,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] sync_bus,
  input  logic                 enable_pulse,
  output logic [BUS_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ADDR_W:0]      level,
  output logic                 overflow,
  input  logic                 clr_overflow
);

  localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0]    wr_ptr;
  logic [ADDR_W-1:0]    rd_ptr;
  logic [BUS_WIDTH-1:0] rdata;
  logic                 push;
  logic                 pop;
  logic                 drop;

  // A full buffer still accepts a word when the head leaves in the same cycle.
  assign pop  = out_valid && out_ready;
  assign push = enable_pulse && ((level != FULL_LEVEL) || pop);
  assign drop = enable_pulse && !push;

  assign out_valid = (level != '0);
  assign out_data  = out_valid ? rdata : '0;

  sync_buf_mem #(
    .BUS_WIDTH (BUS_WIDTH),
    .DEPTH     (DEPTH)
  ) u_mem (
    .clk   (CLK),
    .we    (push && !RST),
    .waddr (wr_ptr),
    .wdata (sync_bus),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      if (push && !pop) begin
        level <= level + (ADDR_W+1)'(1);
      end else if (pop && !push) begin
        level <= level - (ADDR_W+1)'(1);
      end
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule : sync_word_buffer

// File: tb/tb_sync_word_buffer.sv
// Self-checking bench for sync_word_buffer: directed scenarios plus random
// traffic compared against a queue-based FIFO model.
module tb_sync_word_buffer;

  localparam int DEPTH = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] sync_bus = '0;
  logic       enable_pulse = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [2:0] level;
  logic       overflow;
  logic       clr_overflow = 1'b0;

  int total = 0;
  int bad   = 0;

  logic [7:0] q [$];
  logic       m_ov = 1'b0;

  sync_word_buffer #(.BUS_WIDTH(8), .DEPTH(DEPTH)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .sync_bus     (sync_bus),
    .enable_pulse (enable_pulse),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .level        (level),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  always #5 CLK = ~CLK;

  function automatic logic       m_valid(); return q.size() != 0; endfunction
  function automatic logic [7:0] m_data();  return (q.size() != 0) ? q[0] : 8'h00; endfunction
  function automatic logic [2:0] m_level(); return 3'(q.size()); endfunction

  // Drive one cycle of inputs, advance one edge, update the model, settle.
  task automatic step(input logic en, input logic [7:0] d, input logic rdy,
                      input logic clr, input logic rst);
    logic do_pop, do_push;
    enable_pulse = en;
    sync_bus     = d;
    out_ready    = rdy;
    clr_overflow = clr;
    RST          = rst;
    @(posedge CLK);
    if (rst) begin
      q.delete();
      m_ov = 1'b0;
    end else begin
      do_pop  = (q.size() != 0) && rdy;
      do_push = en && ((q.size() < DEPTH) || do_pop);
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(d);
      if (en && !do_push) m_ov = 1'b1;
      else if (clr) m_ov = 1'b0;
    end
    #1;
    enable_pulse = 1'b0;
    clr_overflow = 1'b0;
    RST          = 1'b0;
  endtask

  task automatic test_reset();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    total++;
    if ({out_valid, out_data, level, overflow} !== {1'b0, 8'h00, 3'd0, 1'b0}) begin
      bad++;
      $display("FAIL reset: got v=%0b d=%h l=%0d o=%0b want v=0 d=00 l=0 o=0",
               out_valid, out_data, level, overflow);
    end
  endtask

  task automatic test_single();
    step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    total++;
    if ({out_valid, out_data, level} !== {1'b1, 8'hA5, 3'd1}) begin
      bad++;
      $display("FAIL single_push: got v=%0b d=%h l=%0d want v=1 d=a5 l=1",
               out_valid, out_data, level);
    end
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    total++;
    if ({out_valid, out_data} !== {1'b1, 8'hA5}) begin
      bad++;
      $display("FAIL single_hold: got v=%0b d=%h want v=1 d=a5", out_valid, out_data);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    total++;
    if ({out_valid, out_data, level} !== {1'b0, 8'h00, 3'd0}) begin
      bad++;
      $display("FAIL single_pop: got v=%0b d=%h l=%0d want v=0 d=00 l=0",
               out_valid, out_data, level);
    end
  endtask

  task automatic test_fill_overflow();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      total++;
      if (overflow !== 1'b0) begin
        bad++;
        $display("FAIL fill_no_ov_early: pulse %0d got o=%0b want o=0", i, overflow);
      end
      step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    end
    total++;
    if ({level, overflow} !== {3'd4, 1'b1}) begin
      bad++;
      $display("FAIL fill_overflow: got l=%0d o=%0b want l=4 o=1", level, overflow);
    end
    for (int i = 1; i <= 4; i++) begin
      total++;
      if ({out_valid, out_data} !== {1'b1, 8'(i)}) begin
        bad++;
        $display("FAIL drain_order: got v=%0b d=%h want v=1 d=%h", out_valid, out_data, 8'(i));
      end
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    total++;
    if ({out_valid, level} !== {1'b0, 3'd0}) begin
      bad++;
      $display("FAIL drain_empty: got v=%0b l=%0d want v=0 l=0", out_valid, level);
    end
  endtask

  task automatic test_full_push_pop();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h14, 1'b1, 1'b0, 1'b0);
    total++;
    if ({level, overflow, out_data} !== {3'd4, 1'b0, 8'h11}) begin
      bad++;
      $display("FAIL full_push_pop: got l=%0d o=%0b d=%h want l=4 o=0 d=11",
               level, overflow, out_data);
    end
    for (int i = 1; i <= 4; i++) begin
      total++;
      if ({out_valid, out_data} !== {1'b1, 8'h10 + 8'(i)}) begin
        bad++;
        $display("FAIL full_drain: got v=%0b d=%h want v=1 d=%h",
                 out_valid, out_data, 8'h10 + 8'(i));
      end
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic test_overflow_clear();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
    total++;
    if ({overflow, level, out_data} !== {1'b1, 3'd4, 8'h30}) begin
      bad++;
      $display("FAIL clr_race: got o=%0b l=%0d d=%h want o=1 l=4 d=30", overflow, level, out_data);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL clr_plain: got o=%0b want o=0", overflow);
    end
  endtask

  task automatic test_wrap_reset();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 8'h20 + 8'(i), 1'b1, 1'b0, 1'b0);
      total++;
      if ({out_valid, out_data} !== {1'b1, 8'h20 + 8'(i)} || level > 3'd1) begin
        bad++;
        $display("FAIL wrap: got v=%0b d=%h l=%0d want v=1 d=%h l<=1",
                 out_valid, out_data, level, 8'h20 + 8'(i));
      end
    end
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h66, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b0, 1'b0, 1'b1);
    total++;
    if ({out_valid, out_data, level, overflow} !== {1'b0, 8'h00, 3'd0, 1'b0}) begin
      bad++;
      $display("FAIL mid_reset: got v=%0b d=%h l=%0d o=%0b want v=0 d=00 l=0 o=0",
               out_valid, out_data, level, overflow);
    end
  endtask

  task automatic test_random();
    logic en, rdy, clr, rst;
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 400; i++) begin
      en  = ($urandom_range(0, 99) < 60);
      rdy = ($urandom_range(0, 99) < 45);
      clr = ($urandom_range(0, 99) < 10);
      rst = ($urandom_range(0, 99) < 2);
      step(en, 8'($urandom), rdy, clr, rst);
      total++;
      if ({out_valid, out_data, level, overflow} !== {m_valid(), m_data(), m_level(), m_ov}) begin
        bad++;
        $display("FAIL random cyc %0d: got v=%0b d=%h l=%0d o=%0b want v=%0b d=%h l=%0d o=%0b",
                 i, out_valid, out_data, level, overflow, m_valid(), m_data(), m_level(), m_ov);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_full_push_pop();
    test_overflow_clear();
    test_wrap_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_sync_word_buffer
